// File: rtl/wb_pkg.sv
// Writeback arbitration shared types and constants.
// WB_BYPASS_EN (in wb_arbiter) enables GPR forwarding of the in-flight write.
package wb_pkg;
  localparam int NSRC      = 3;
  localparam int RR_W      = 2;
  localparam int SRC_ALU   = 0;
  localparam int SRC_MEM   = 1;
  localparam int SRC_FPU   = 2;
  localparam int WB_DATA_W = 32;
  localparam int WB_REG_AW = 5;

  typedef struct packed {
    logic [WB_REG_AW-1:0] wreg;
    logic [WB_DATA_W-1:0] wdata;
    logic                 w_en;
    logic                 w_byte;
  } wb_wr_t;

  function automatic logic [RR_W-1:0] rr_next(
    input logic [RR_W-1:0] i
  );
    return (i == RR_W'(NSRC - 1)) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/wb_rr_arb.sv
// 3-way round-robin arbiter: one-hot grant, pointer
// moves to the slot after the winner.
module wb_rr_arb
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] i_req,
  output logic [NSRC-1:0] o_gnt
);
  logic [RR_W-1:0] r_ptr;
  logic [RR_W-1:0] w_idx;
  logic [RR_W-1:0] w_win;
  logic            w_hit;

  always_comb begin
    o_gnt = '0;
    w_hit = 1'b0;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int k = 0; k < NSRC; k++) begin
      if (!w_hit && !rst && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_hit        = 1'b1;
        w_win        = w_idx;
      end
      w_idx = rr_next(w_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_hit) begin
      r_ptr <= rr_next(w_win);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin GPR/FPR write arbitration.
// WB_BYPASS_EN adds combinational GPR read forwarding.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC-1:0]        src_fp,
  input  logic [NSRC-1:0]        src_byte,
  input  logic [NSRC*REG_AW-1:0] src_rd,
  input  logic [NSRC*DATA_W-1:0] src_data,
  output logic [NSRC-1:0]        src_ready,
  output logic [REG_AW-1:0]      gpr_wreg,
  output logic [DATA_W-1:0]      gpr_wdata,
  output logic                   gpr_w_en,
  output logic                   gpr_w_byte,
  output logic [REG_AW-1:0]      fpr_wreg,
  output logic [DATA_W-1:0]      fpr_wdata,
  output logic                   fpr_w_en,
  output logic                   fpr_w_byte,
  output logic                   busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0]      gpr_rreg1,
  input  logic [REG_AW-1:0]      gpr_rreg2,
  input  logic [DATA_W-1:0]      gpr_rdata1_in,
  input  logic [DATA_W-1:0]      gpr_rdata2_in,
  output logic [DATA_W-1:0]      gpr_rdata1_out,
  output logic [DATA_W-1:0]      gpr_rdata2_out
`endif
);
  logic [NSRC-1:0] w_req_g;
  logic [NSRC-1:0] w_req_f;
  logic [NSRC-1:0] w_gnt_g;
  logic [NSRC-1:0] w_gnt_f;
  wb_wr_t          w_nxt_g;
  wb_wr_t          w_nxt_f;
  wb_wr_t          r_gpr;
  wb_wr_t          r_fpr;

  assign w_req_g = src_valid & ~src_fp;
  assign w_req_f = src_valid & src_fp;

  wb_rr_arb u_arb_gpr (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req_g),
    .o_gnt (w_gnt_g)
  );

  wb_rr_arb u_arb_fpr (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req_f),
    .o_gnt (w_gnt_f)
  );

  assign src_ready = w_gnt_g | w_gnt_f;

  // Index/data hold across idle cycles; only w_en drops.
  always_comb begin
    w_nxt_g      = r_gpr;
    w_nxt_f      = r_fpr;
    w_nxt_g.w_en = 1'b0;
    w_nxt_f.w_en = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_gnt_g[i]) begin
        w_nxt_g.wreg   = src_rd[i*REG_AW +: REG_AW];
        w_nxt_g.wdata  = src_data[i*DATA_W +: DATA_W];
        w_nxt_g.w_byte = src_byte[i];
        w_nxt_g.w_en   = |src_rd[i*REG_AW +: REG_AW];
      end
      if (w_gnt_f[i]) begin
        w_nxt_f.wreg   = src_rd[i*REG_AW +: REG_AW];
        w_nxt_f.wdata  = src_data[i*DATA_W +: DATA_W];
        w_nxt_f.w_byte = src_byte[i];
        w_nxt_f.w_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpr <= '0;
      r_fpr <= '0;
    end else begin
      r_gpr <= w_nxt_g;
      r_fpr <= w_nxt_f;
    end
  end

  assign gpr_wreg   = r_gpr.wreg;
  assign gpr_wdata  = r_gpr.wdata;
  assign gpr_w_en   = r_gpr.w_en;
  assign gpr_w_byte = r_gpr.w_byte;
  assign fpr_wreg   = r_fpr.wreg;
  assign fpr_wdata  = r_fpr.wdata;
  assign fpr_w_en   = r_fpr.w_en;
  assign fpr_w_byte = r_fpr.w_byte;
  assign busy       = r_gpr.w_en | r_fpr.w_en;

`ifdef WB_BYPASS_EN
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] rreg,
    input logic [DATA_W-1:0] rin
  );
    if (!(r_gpr.w_en && r_gpr.wreg == rreg)) return rin;
    if (r_gpr.w_byte) return {rin[DATA_W-1:8], r_gpr.wdata[7:0]};
    return r_gpr.wdata;
  endfunction

  assign gpr_rdata1_out = fwd(gpr_rreg1, gpr_rdata1_in);
  assign gpr_rdata2_out = fwd(gpr_rreg2, gpr_rdata2_in);
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  src_valid = '0;
  logic [2:0]  src_fp = '0;
  logic [2:0]  src_byte = '0;
  logic [14:0] src_rd = '0;
  logic [95:0] src_data = '0;
  logic [2:0]  src_ready;
  logic [4:0]  gpr_wreg, fpr_wreg;
  logic [31:0] gpr_wdata, fpr_wdata;
  logic        gpr_w_en, gpr_w_byte;
  logic        fpr_w_en, fpr_w_byte;
  logic        busy;
`ifdef WB_BYPASS_EN
  logic [4:0]  gpr_rreg1 = '0, gpr_rreg2 = '0;
  logic [31:0] gpr_rdata1_in = '0, gpr_rdata2_in = '0;
  logic [31:0] gpr_rdata1_out, gpr_rdata2_out;
`endif

  int checks = 0;
  int failures = 0;

  // model state
  int          mp_g = 0, mp_f = 0;
  logic        eg_en = 0, ef_en = 0;
  logic        eg_b = 0, ef_b = 0;
  logic [4:0]  eg_r = 0, ef_r = 0;
  logic [31:0] eg_d = 0, ef_d = 0;

  wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_fp     (src_fp),
    .src_byte   (src_byte),
    .src_rd     (src_rd),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .gpr_wreg   (gpr_wreg),
    .gpr_wdata  (gpr_wdata),
    .gpr_w_en   (gpr_w_en),
    .gpr_w_byte (gpr_w_byte),
    .fpr_wreg   (fpr_wreg),
    .fpr_wdata  (fpr_wdata),
    .fpr_w_en   (fpr_w_en),
    .fpr_w_byte (fpr_w_byte),
    .busy       (busy)
`ifdef WB_BYPASS_EN
    ,
    .gpr_rreg1      (gpr_rreg1),
    .gpr_rreg2      (gpr_rreg2),
    .gpr_rdata1_in  (gpr_rdata1_in),
    .gpr_rdata2_in  (gpr_rdata2_in),
    .gpr_rdata1_out (gpr_rdata1_out),
    .gpr_rdata2_out (gpr_rdata2_out)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] pick(
    input logic [2:0] req, input int p
  );
    logic [2:0] g;
    g = '0;
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (p + k) % 3;
      if (req[j] && g == 3'b000) g[j] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [2:0] exp_ready();
    if (rst) return 3'b000;
    return pick(src_valid & ~src_fp, mp_g)
         | pick(src_valid & src_fp, mp_f);
  endfunction

  // Advance one clock; update model from inputs seen at the edge.
  task automatic tick();
    logic [2:0] gg, gf;
    logic       r;
    gg = pick(src_valid & ~src_fp, mp_g);
    gf = pick(src_valid & src_fp, mp_f);
    r  = rst;
    @(posedge clk);
    if (r) begin
      mp_g = 0; mp_f = 0;
      eg_en = 0; ef_en = 0; eg_b = 0; ef_b = 0;
      eg_r = 0; ef_r = 0; eg_d = 0; ef_d = 0;
    end else begin
      eg_en = 0;
      ef_en = 0;
      for (int i = 0; i < 3; i++) begin
        if (gg[i]) begin
          eg_r  = src_rd[i*5 +: 5];
          eg_d  = src_data[i*32 +: 32];
          eg_b  = src_byte[i];
          eg_en = (eg_r != 0);
          mp_g  = (i + 1) % 3;
        end
        if (gf[i]) begin
          ef_r  = src_rd[i*5 +: 5];
          ef_d  = src_data[i*32 +: 32];
          ef_b  = src_byte[i];
          ef_en = 1'b1;
          mp_f  = (i + 1) % 3;
        end
      end
    end
    #1;
  endtask

  task automatic drive(
    input int i, input logic fp, input logic b,
    input logic [4:0] rd, input logic [31:0] d
  );
    src_valid[i]        = 1'b1;
    src_fp[i]           = fp;
    src_byte[i]         = b;
    src_rd[i*5 +: 5]    = rd;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = 3'b111;
    src_fp = 3'b100;
    src_rd = 15'($urandom);
    src_data = {$urandom, $urandom, $urandom};
    tick();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({src_ready, gpr_w_en, fpr_w_en, busy,
           gpr_wreg, gpr_wdata, gpr_w_byte,
           fpr_wreg, fpr_wdata, fpr_w_byte} !== '0) begin
        failures++;
        $display("FAIL reset: ready=%b gen=%b fen=%b busy=%b gd=%h fd=%h want all 0",
                 src_ready, gpr_w_en, fpr_w_en, busy,
                 gpr_wdata, fpr_wdata);
      end
      tick();
    end
    rst = 1'b0;
    src_valid = '0;
  endtask

  task automatic test_single_alu();
    drive(0, 1'b0, 1'b0, 5'd5, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (src_ready !== 3'b001) begin
      failures++;
      $display("FAIL single_ready: got %b want 001", src_ready);
    end
    tick();
    src_valid = '0;
    @(negedge clk);
    checks++;
    if ({gpr_w_en, gpr_wreg, gpr_wdata, fpr_w_en}
        !== {1'b1, 5'd5, 32'h1234_5678, 1'b0}) begin
      failures++;
      $display("FAIL single_write: en=%b wreg=%0d wdata=%h fen=%b want 1/5/12345678/0",
               gpr_w_en, gpr_wreg, gpr_wdata, fpr_w_en);
    end
    tick();
  endtask

  task automatic test_gpr_contention();
    logic [2:0] want;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 5'd1, $urandom);
    drive(1, 1'b0, 1'b0, 5'd2, $urandom);
    for (int c = 0; c < 4; c++) begin
      want = (c % 2 == 0) ? 3'b001 : 3'b010;
      @(negedge clk);
      checks++;
      if (src_ready !== want) begin
        failures++;
        $display("FAIL contention_grant%0d: got %b want %b",
                 c, src_ready, want);
      end
      if (c > 0) begin
        checks++;
        if (gpr_w_en !== 1'b1 || gpr_wdata !== eg_d) begin
          failures++;
          $display("FAIL contention_wen%0d: en=%b d=%h want 1/%h",
                   c, gpr_w_en, gpr_wdata, eg_d);
        end
      end
      tick();
      if (want[0]) drive(0, 1'b0, 1'b0, 5'($urandom_range(1, 31)), $urandom);
      else         drive(1, 1'b0, 1'b0, 5'($urandom_range(1, 31)), $urandom);
    end
    src_valid = '0;
    @(negedge clk);
    checks++;
    if (gpr_w_en !== 1'b1 || gpr_wdata !== eg_d) begin
      failures++;
      $display("FAIL contention_last: en=%b d=%h want 1/%h",
               gpr_w_en, gpr_wdata, eg_d);
    end
    tick();
  endtask

  task automatic test_parallel();
    drive(1, 1'b0, 1'b0, 5'd3, 32'hAAAA_0001);
    drive(2, 1'b1, 1'b0, 5'd3, 32'h5555_0002);
    @(negedge clk);
    checks++;
    if (src_ready !== 3'b110) begin
      failures++;
      $display("FAIL parallel_ready: got %b want 110", src_ready);
    end
    tick();
    src_valid = '0;
    @(negedge clk);
    checks++;
    if ({gpr_w_en, fpr_w_en, gpr_wreg, fpr_wreg, gpr_wdata, fpr_wdata}
        !== {2'b11, 5'd3, 5'd3, 32'hAAAA_0001, 32'h5555_0002}) begin
      failures++;
      $display("FAIL parallel_write: gen=%b fen=%b gd=%h fd=%h want 1/1/aaaa0001/55550002",
               gpr_w_en, fpr_w_en, gpr_wdata, fpr_wdata);
    end
    tick();
  endtask

  task automatic test_index0_byte();
    drive(0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF);
    drive(2, 1'b1, 1'b1, 5'd0, 32'h0000_00AB);
    @(negedge clk);
    checks++;
    if (src_ready !== 3'b101) begin
      failures++;
      $display("FAIL idx0_ready: got %b want 101", src_ready);
    end
    tick();
    src_valid = '0;
    @(negedge clk);
    checks++;
    if (gpr_w_en !== 1'b0) begin
      failures++;
      $display("FAIL idx0_gpr: gpr_w_en=%b want 0", gpr_w_en);
    end
    checks++;
    if ({fpr_w_en, fpr_w_byte, fpr_wreg, fpr_wdata, busy}
        !== {2'b11, 5'd0, 32'h0000_00AB, 1'b1}) begin
      failures++;
      $display("FAIL idx0_fpr: en=%b byte=%b reg=%0d d=%h busy=%b want 1/1/0/ab/1",
               fpr_w_en, fpr_w_byte, fpr_wreg, fpr_wdata, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b0, 1'b0, 5'd9, $urandom);
    tick();
    src_valid = '0;
    drive(1, 1'b0, 1'b0, 5'd10, $urandom);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (src_ready !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_ready: got %b want 000", src_ready);
    end
    tick();
    rst = 1'b0;
    src_valid = '0;
    @(negedge clk);
    checks++;
    if ({gpr_w_en, fpr_w_en, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_wen: gen=%b fen=%b busy=%b want 0",
               gpr_w_en, fpr_w_en, busy);
    end
    tick();
  endtask

  task automatic test_random();
    logic [2:0] acc;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      acc = exp_ready();
      checks++;
      if (src_ready !== acc) begin
        failures++;
        $display("FAIL rand_ready c%0d: got %b want %b", c, src_ready, acc);
      end
      checks++;
      if ({gpr_w_en, gpr_wreg, gpr_wdata, gpr_w_byte}
          !== {eg_en, eg_r, eg_d, eg_b}) begin
        failures++;
        $display("FAIL rand_gpr c%0d: got %b/%0d/%h/%b want %b/%0d/%h/%b",
                 c, gpr_w_en, gpr_wreg, gpr_wdata, gpr_w_byte,
                 eg_en, eg_r, eg_d, eg_b);
      end
      checks++;
      if ({fpr_w_en, fpr_wreg, fpr_wdata, fpr_w_byte}
          !== {ef_en, ef_r, ef_d, ef_b}) begin
        failures++;
        $display("FAIL rand_fpr c%0d: got %b/%0d/%h/%b want %b/%0d/%h/%b",
                 c, fpr_w_en, fpr_wreg, fpr_wdata, fpr_w_byte,
                 ef_en, ef_r, ef_d, ef_b);
      end
      checks++;
      if (busy !== (eg_en | ef_en)) begin
        failures++;
        $display("FAIL rand_busy c%0d: got %b want %b",
                 c, busy, eg_en | ef_en);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        if (!src_valid[i] || acc[i]) begin
          src_valid[i] = 1'b0;
          if ($urandom_range(0, 9) < 6)
            drive(i, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 5'd0
                    : 5'($urandom_range(1, 31)),
                  $urandom);
        end
      end
    end
    rst = 1'b0;
    src_valid = '0;
    tick();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    logic [31:0] r1, r2;
    r1 = $urandom;
    r2 = $urandom;
    drive(0, 1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF);
    tick();
    src_valid = '0;
    gpr_rreg1 = 5'd7;
    gpr_rreg2 = 5'd8;
    gpr_rdata1_in = r1;
    gpr_rdata2_in = r2;
    @(negedge clk);
    checks++;
    if (gpr_rdata1_out !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL bypass_hit: got %h want deadbeef", gpr_rdata1_out);
    end
    checks++;
    if (gpr_rdata2_out !== r2) begin
      failures++;
      $display("FAIL bypass_miss: got %h want %h", gpr_rdata2_out, r2);
    end
    tick();
    drive(0, 1'b0, 1'b1, 5'd7, 32'h1111_22CD);
    tick();
    src_valid = '0;
    @(negedge clk);
    checks++;
    if (gpr_rdata1_out !== {r1[31:8], 8'hCD}) begin
      failures++;
      $display("FAIL bypass_byte: got %h want %h",
               gpr_rdata1_out, {r1[31:8], 8'hCD});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_alu();
    test_gpr_contention();
    test_parallel();
    test_index0_byte();
    test_reset_mid();
    test_random();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
